// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame link; also used by the slave-side transmitter.
package serial_frame_receiver_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrParity  = 2'b01;
  localparam logic [1:0] ErrStop    = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  // Start bit + two data words + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_width);
    return 2 * data_width + 3;
  endfunction

endpackage

// File: rtl/serial_frame_shifter.sv
// MSB-first shift register with bit counter and running even parity.
module serial_frame_shifter #(
  parameter int unsigned Width  = 32,
  parameter int unsigned CountW = $clog2(Width + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_shift_en,
  input  logic              i_bit,
  output logic [Width-1:0]  o_data,
  output logic [CountW-1:0] o_count,
  output logic              o_parity
);

  logic [Width-1:0]  r_data;
  logic [CountW-1:0] r_count;
  logic              r_parity;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data   <= '0;
      r_count  <= '0;
      r_parity <= 1'b0;
    end else if (i_clear) begin
      r_data   <= '0;
      r_count  <= '0;
      r_parity <= 1'b0;
    end else if (i_shift_en) begin
      r_data   <= {r_data[Width-2:0], i_bit};
      r_count  <= r_count + CountW'(1);
      r_parity <= r_parity ^ i_bit;
    end
  end

  assign o_data   = r_data;
  assign o_count  = r_count;
  assign o_parity = r_parity;

endmodule

// File: rtl/serial_frame_receiver.sv
// Receives a start/data/parity/stop frame from the slave ADC node and reports
// the two sample words or an error code.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_adc,
  input  logic                  serial_data,
  output logic [DATA_WIDTH-1:0] sample_a,
  output logic [DATA_WIDTH-1:0] sample_b,
  output logic                  sample_valid,
  output logic                  frame_error,
  output logic [1:0]            error_code,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned DataBits = frame_bits(DATA_WIDTH) - 3;
  localparam int unsigned CountW   = $clog2(DataBits + 1);
  localparam int unsigned TimerW   = $clog2(START_TIMEOUT + 1);
  localparam logic [CountW-1:0] LastBit  = CountW'(DataBits - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(START_TIMEOUT - 1);

  state_e                r_state;
  logic [TimerW-1:0]     r_timer;
  logic                  r_parity_bit;
  logic [DATA_WIDTH-1:0] r_sample_a;
  logic [DATA_WIDTH-1:0] r_sample_b;
  logic                  r_valid;
  logic                  r_error;
  logic [1:0]            r_code;
  logic                  r_overrun;

  logic [DataBits-1:0] w_data;
  logic [CountW-1:0]   w_count;
  logic                w_parity;
  logic                w_busy;

  assign w_busy = (r_state != StIdle);

  serial_frame_shifter #(
    .Width  (DataBits),
    .CountW (CountW)
  ) u_shifter (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_clear    (r_state == StWaitStart),
    .i_shift_en (r_state == StData),
    .i_bit      (serial_data),
    .o_data     (w_data),
    .o_count    (w_count),
    .o_parity   (w_parity)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_timer      <= '0;
      r_parity_bit <= 1'b0;
      r_sample_a   <= '0;
      r_sample_b   <= '0;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
      r_code       <= ErrNone;
      r_overrun    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_overrun <= start_adc && w_busy;
      case (r_state)
        StIdle: begin
          if (start_adc) begin
            r_state <= StWaitStart;
            // The arm cycle itself counts toward the timeout window.
            r_timer <= TimerW'(1);
          end
        end
        StWaitStart: begin
          if (!serial_data) begin
            r_state <= StData;
          end else if (r_timer >= TimerMax) begin
            r_state <= StIdle;
            r_error <= 1'b1;
            r_code  <= ErrTimeout;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end
        StData: begin
          if (w_count == LastBit) begin
            r_state <= StParity;
          end
        end
        StParity: begin
          r_parity_bit <= serial_data;
          r_state      <= StStop;
        end
        StStop: begin
          r_state <= StIdle;
          if (r_parity_bit != w_parity) begin
            r_error <= 1'b1;
            r_code  <= ErrParity;
          end else if (!serial_data) begin
            r_error <= 1'b1;
            r_code  <= ErrStop;
          end else begin
            r_valid    <= 1'b1;
            r_code     <= ErrNone;
            r_sample_a <= w_data[DataBits-1 -: DATA_WIDTH];
            r_sample_b <= w_data[DATA_WIDTH-1:0];
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sample_a     = r_sample_a;
  assign sample_b     = r_sample_b;
  assign sample_valid = r_valid;
  assign frame_error  = r_error;
  assign error_code   = r_code;
  assign busy         = w_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed scoreboard bench for serial_frame_receiver.
module tb_serial_frame_receiver;
  import serial_frame_receiver_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 64;
  localparam int          LAT = 2 * DW + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_adc;
  logic          serial_data;
  logic [DW-1:0] sample_a;
  logic [DW-1:0] sample_b;
  logic          sample_valid;
  logic          frame_error;
  logic [1:0]    error_code;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int            at;
    logic          valid;
    logic [1:0]    code;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          sb[$];
  exp_t          m_e;
  logic [DW-1:0] m_a = '0;
  logic [DW-1:0] m_b = '0;

  serial_frame_receiver #(
    .DATA_WIDTH    (DW),
    .START_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_adc    (start_adc),
    .serial_data  (serial_data),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .sample_valid (sample_valid),
    .frame_error  (frame_error),
    .error_code   (error_code),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (sample_valid || frame_error) begin
      chk("valid_error_exclusive", 64'(sample_valid & frame_error), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'({sample_valid, frame_error}), 64'd0);
      end else begin
        m_e = sb.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(m_e.at));
        chk("pulse_valid", 64'(sample_valid), 64'(m_e.valid));
        chk("pulse_error", 64'(frame_error), 64'(!m_e.valid));
        chk("error_code", 64'(error_code), 64'(m_e.code));
        chk("sample_a", 64'(sample_a), 64'(m_e.a));
        chk("sample_b", 64'(sample_b), 64'(m_e.b));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, 64'(sample_a), 64'd0);
    chk({tag, "_b"}, 64'(sample_b), 64'd0);
    chk({tag, "_pulses"}, 64'({sample_valid, frame_error, overrun}), 64'd0);
    chk({tag, "_code"}, 64'(error_code), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_state"}, 64'(dut.r_state), 64'(StIdle));
  endtask

  task automatic run_frame(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic par,
                           input logic stp, input int gap, input int ovr_at, input int rst_at);
    logic [2*DW-1:0] bits;
    exp_t            e;
    int              s;
    bits        = {a, b};
    start_adc   = 1'b1;
    serial_data = 1'b1;
    tick();
    start_adc = 1'b0;
    chk("no_overrun_on_idle_arm", 64'(overrun), 64'd0);
    repeat (gap - 1) tick();
    s           = cyc;
    serial_data = 1'b0;
    if (rst_at == 0) begin
      e.at = s + LAT;
      if (par != ^bits) begin
        e.valid = 1'b0; e.code = ErrParity; e.a = m_a; e.b = m_b;
      end else if (!stp) begin
        e.valid = 1'b0; e.code = ErrStop; e.a = m_a; e.b = m_b;
      end else begin
        e.valid = 1'b1; e.code = ErrNone; e.a = a; e.b = b;
        m_a = a; m_b = b;
      end
      sb.push_back(e);
    end
    tick();
    for (int i = 0; i < 2 * DW; i++) begin
      serial_data = bits[2*DW-1-i];
      if (i + 1 == rst_at) begin
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        tick();
        reset       = 1'b0;
        serial_data = 1'b1;
        m_a         = '0;
        m_b         = '0;
        repeat (LAT + 10) tick();
        chk("idle_after_reset", 64'(busy), 64'd0);
        return;
      end
      if (i + 1 == ovr_at) start_adc = 1'b1;
      tick();
      start_adc = 1'b0;
      if (i + 1 == ovr_at) chk("overrun_pulse", 64'(overrun), 64'd1);
    end
    serial_data = par;
    tick();
    serial_data = stp;
    tick();
    serial_data = 1'b1;
  endtask

  task automatic run_timeout();
    exp_t e;
    int   a;
    a           = cyc;
    start_adc   = 1'b1;
    serial_data = 1'b1;
    e.at = a + TO; e.valid = 1'b0; e.code = ErrTimeout; e.a = m_a; e.b = m_b;
    sb.push_back(e);
    tick();
    start_adc = 1'b0;
    while (cyc < a + TO - 1) tick();
    chk("busy_before_timeout", 64'(busy), 64'd1);
    tick();
    tick();
    chk("busy_after_timeout", 64'(busy), 64'd0);
    chk("code_held_after_timeout", 64'(error_code), 64'(ErrTimeout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start_adc   = 1'b0;
    serial_data = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) tick();

    run_frame(16'hA5C3, 16'h0F0F, 1'b0, 1'b1, 5, 0, 0);
    tick();
    chk("code_held_after_valid", 64'(error_code), 64'(ErrNone));
    run_frame(16'hA5C3, 16'h0F0F, 1'b1, 1'b1, 5, 0, 0);
    tick();
    run_frame(16'h0001, 16'h0000, 1'b1, 1'b0, 5, 0, 0);
    tick();
    run_timeout();
    tick();
    run_frame(16'h5A5A, 16'h1234, ^{16'h5A5A, 16'h1234}, 1'b1, 3, 10, 0);
    // Arm again in the very cycle the previous frame reports.
    run_frame(16'hBEEF, 16'h8001, ^{16'hBEEF, 16'h8001}, 1'b1, 1, 0, 0);
    tick();
    run_frame(16'hCAFE, 16'h0F0F, 1'b0, 1'b1, 4, 0, 20);
    run_frame(16'h1234, 16'hFFFF, ^{16'h1234, 16'hFFFF}, 1'b1, 5, 0, 0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per ADC sample.
REQ-002 SHALL have parameter START_TIMEOUT, default 64, cycles allowed from arm to start bit.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  in  1  system clock, shared with the slave node transmitter.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: start_adc  in  1  one-cycle arm pulse, the same pulse sent to the slave node.
REQ-007 Port: serial_data  in  1  slave frame line; idles high; one bit per clk.
REQ-008 Port: sample_a  out  DATA_WIDTH  first channel word of the last good frame.
REQ-009 Port: sample_b  out  DATA_WIDTH  second channel word of the last good frame.
REQ-010 Port: sample_valid  out  1  one-cycle pulse; sample_a/sample_b are updated in that same cycle.
REQ-011 Port: frame_error  out  1  one-cycle pulse on a failed frame.
REQ-012 Port: error_code  out  2  00 none, 01 parity, 10 stop bit, 11 timeout; held until the next valid or error.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: overrun  out  1  one-cycle pulse when start_adc arrives while busy.

Function
REQ-015 Frame format SHALL be: start bit 0, then sample_a MSB-first, then sample_b MSB-first, then an even-parity bit over the 2*DATA_WIDTH data bits, then stop bit 1.
REQ-016 States SHALL be IDLE, WAIT_START, DATA, PARITY, STOP.
REQ-017 IDLE SHALL move to WAIT_START on the cycle after start_adc is sampled high.
REQ-018 WAIT_START SHALL move to DATA when serial_data is sampled 0.
REQ-019 WAIT_START SHALL time out once START_TIMEOUT cycles elapse with no start bit.
REQ-020 On timeout the block SHALL return to IDLE, pulse frame_error and set error_code to 11.
REQ-021 DATA SHALL shift in exactly 2*DATA_WIDTH bits, one per cycle, and then move to PARITY.
REQ-022 PARITY SHALL sample one bit and move to STOP.
REQ-023 STOP SHALL sample one bit and return to IDLE.
REQ-024 Checks SHALL be applied at STOP with this priority: a parity mismatch gives code 01; otherwise stop bit 0 gives code 10; otherwise the frame is good.
REQ-025 Latency: if the start bit is sampled at cycle S, sample_valid or frame_error SHALL pulse at S+2*DATA_WIDTH+3 (S+35 for the default).
REQ-026 sample_valid and frame_error SHALL never be high in the same cycle.
REQ-027 On a good frame the block SHALL update sample_a/sample_b and set error_code to 00.
REQ-028 On any error the block SHALL leave sample_a/sample_b unchanged.
REQ-029 start_adc while busy SHALL be ignored by the FSM and SHALL pulse overrun on the following cycle.
REQ-030 start_adc SHALL be accepted in the same cycle the FSM returns to IDLE; a back-to-back arm is legal.
REQ-031 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-032 The bit counter SHALL be sized ceil(log2(2*DATA_WIDTH+1)).

Reset
REQ-033 While reset is asserted the state SHALL be IDLE.
REQ-034 While reset is asserted all outputs, counters and shift registers SHALL be 0.
REQ-035 Reset mid-frame SHALL abort the frame immediately, with no valid or error pulse.
REQ-036 After reset is released the block SHALL wait for a fresh start_adc.

Structure
REQ-037 A shared package SHALL hold the state enum, the error_code constants, and a FRAME_BITS = 2*DATA_WIDTH+3 function.
REQ-038 The package SHALL be reused by the slave-side transmitter.
REQ-039 The design SHALL have one sub-module, serial_frame_shifter: an MSB-first shift register with bit counter and running parity.
REQ-040 The FSM, timeout counter and output registers SHALL stay in the top module.

Verification
REQ-041 Good frame: start_adc, start bit 5 cycles later, a=16'hA5C3, b=16'h0F0F, parity 0, stop 1 -> sample_valid at S+35, outputs A5C3/0F0F, error_code 00.
REQ-042 Parity error: same frame with parity bit 1 -> frame_error, error_code 01, sample_a/sample_b retain their previous values.
REQ-043 Stop-bit error: a=16'h0001, b=16'h0000, parity 1, stop 0 -> frame_error, error_code 10.
REQ-044 Timeout: start_adc with serial_data held high -> frame_error exactly 64 cycles after the arm, error_code 11, busy low the next cycle.
REQ-045 Overrun: start_adc at S+10 -> overrun pulse at S+11, and the frame still completes at S+35.
REQ-046 Reset mid-frame: reset at S+20 -> outputs 0, state IDLE, no pulses; then a good frame with a=16'h1234, b=16'hFFFF succeeds.
